// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller and its datapath:
// state encodings, opcodes, ALU/PC/operand select codes and the control bundle.
package mips_pkg;

    // FSM state encodings (also exported on the debug state port)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_IMM_EX   = 4'd10;
    localparam logic [3:0] S_IMM_WB   = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    // Opcode field values understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation requests
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source selects
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // All controller outputs except the debug state, grouped for one-place defaults
    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       illegal_op;
        logic       bus_error;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that wait on the memory handshake and are bounded by the timer
    function automatic logic is_mem_state(input logic [3:0] st);
        return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired flags the last allowed wait cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int              CW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over count; the counter saturates at the limit
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with bounded memory waits and illegal-opcode trap.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state
);
    logic [3:0] state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       expired;
    logic       mem_state;
    logic       stay_wait;
    logic       timeout;
    logic       timer_clr;
    ctrl_t      ctrl;

    assign mem_state = is_mem_state(state_q);
    // Still waiting and still within budget: keep counting in the same state
    assign stay_wait = mem_state & ~mem_ready & ~expired;
    // Last allowed cycle passed without a response: abandon the access
    assign timeout   = mem_state & ~mem_ready & expired;
    // Any cycle that is not a continued wait restarts the count, so every
    // memory state (including FETCH re-entered after a timeout) starts at 0
    assign timer_clr = ~stay_wait;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .srst    (reset),
        .clr     (timer_clr),
        .en      (stay_wait),
        .expired (expired)
    );

    // Next-state selection and opcode capture in DECODE
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_IMM_EX;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready || timeout) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IMM_EX: state_d = S_IMM_WB;
            S_IMM_WB: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Per-state control outputs, then timeout and reset write suppression
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_IMM_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_ALUOUT;
                ctrl.pc_en     = (opcode_q == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                ctrl.pc_source = PC_JUMP;
                ctrl.pc_en     = 1'b1;
            end
            S_IMM_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ;
        endcase
        if (timeout) begin
            ctrl.bus_error = 1'b1;
            ctrl.mem_write = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.pc_en     = 1'b0;
        end
        if (reset) begin
            ctrl.pc_en     = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.bus_error = 1'b0;
        end
    end

    // State and latched opcode registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ir_write   = ctrl.ir_write;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign illegal_op = ctrl.illegal_op;
    assign bus_error  = ctrl.bus_error;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: builds an expected cycle trace per instruction
// from memory latencies and instruction class, then replays it against the DUT.
module tb_mips_multicycle_ctrl;
    localparam int TO = 4;

    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4,
                   MEM_WR = 5, EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9,
                   IMM_EX = 10, IMM_WB = 11, TRAP = 12;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       illegal_op;
        logic       bus_error;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } outs_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       z;
        logic [5:0] op;
        logic       rst;
        outs_t      o;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_write, iord, mem_read, mem_write, reg_dst, reg_write;
    logic       mem_to_reg, alu_src_a, illegal_op, bus_error;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int   n_checks = 0;
    int   n_fails  = 0;
    cyc_t q[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // Static outputs of each state as listed in the controller description
    function automatic outs_t st_outs(input int st);
        outs_t o;
        o = '0;
        case (st)
            FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'b01; end
            DECODE:   begin o.alu_src_b = 2'b11; end
            MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            MEM_RD:   begin o.iord = 1; o.mem_read = 1; end
            MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
            MEM_WR:   begin o.iord = 1; o.mem_write = 1; end
            EXEC:     begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            R_WB:     begin o.reg_write = 1; o.reg_dst = 1; end
            BRANCH:   begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; end
            JUMP:     begin o.pc_source = 2'b10; o.pc_en = 1; end
            IMM_EX:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            IMM_WB:   begin o.reg_write = 1; end
            TRAP:     begin o.illegal_op = 1; end
            default:  ;
        endcase
        return o;
    endfunction

    function automatic outs_t rst_gate(input outs_t oi);
        outs_t o;
        o = oi;
        o.pc_en = 0; o.ir_write = 0; o.mem_write = 0; o.reg_write = 0; o.bus_error = 0;
        return o;
    endfunction

    task automatic push(input int st, input logic rdy, input logic z, input logic [5:0] op,
                        input logic rst, input outs_t o);
        cyc_t c;
        c.st = 4'(st); c.rdy = rdy; c.z = z; c.op = op; c.rst = rst; c.o = o;
        q.push_back(c);
    endtask

    // A memory access answered after lat idle cycles; lat >= TO means no answer in time.
    // rst_at >= 0 asserts reset on that idle cycle and abandons the instruction.
    task automatic access(input int st, input int lat, input int rst_at, output bit done);
        outs_t o;
        int    n;
        n    = (lat < TO) ? lat : TO;
        done = 0;
        for (int i = 0; i < n; i++) begin
            o = st_outs(st);
            if (i == rst_at) begin
                push(st, 1'b0, rbit(), rop(), 1'b1, rst_gate(o));
                return;
            end
            if (i == TO - 1) begin
                o.bus_error = 1;
                o.mem_write = 0;
            end
            push(st, 1'b0, rbit(), rop(), 1'b0, o);
        end
        if (lat < TO) begin
            o = st_outs(st);
            if (st == FETCH) begin
                o.pc_en    = 1;
                o.ir_write = 1;
            end
            push(st, 1'b1, rbit(), rop(), 1'b0, o);
            done = 1;
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int lf, input int ld, input logic z,
                             input int rst_at, input int hold);
        bit    done;
        outs_t o;
        access(FETCH, lf, -1, done);
        if (!done) return;
        push(DECODE, rbit(), rbit(), op, 1'b0, st_outs(DECODE));
        case (op)
            OP_R: begin
                push(EXEC, rbit(), rbit(), rop(), 1'b0, st_outs(EXEC));
                push(R_WB, rbit(), rbit(), rop(), 1'b0, st_outs(R_WB));
            end
            OP_LW: begin
                push(MEM_ADDR, rbit(), rbit(), rop(), 1'b0, st_outs(MEM_ADDR));
                access(MEM_RD, ld, rst_at, done);
                if (done) push(MEM_WB, rbit(), rbit(), rop(), 1'b0, st_outs(MEM_WB));
            end
            OP_SW: begin
                push(MEM_ADDR, rbit(), rbit(), rop(), 1'b0, st_outs(MEM_ADDR));
                access(MEM_WR, ld, rst_at, done);
            end
            OP_BEQ, OP_BNE: begin
                o = st_outs(BRANCH);
                o.pc_en = (op == OP_BEQ) ? z : ~z;
                push(BRANCH, rbit(), z, rop(), 1'b0, o);
            end
            OP_J:    push(JUMP, rbit(), rbit(), rop(), 1'b0, st_outs(JUMP));
            OP_ADDI: begin
                push(IMM_EX, rbit(), rbit(), rop(), 1'b0, st_outs(IMM_EX));
                push(IMM_WB, rbit(), rbit(), rop(), 1'b0, st_outs(IMM_WB));
            end
            default: begin
                for (int i = 0; i < hold; i++)
                    push(TRAP, rbit(), rbit(), rop(), 1'b0, st_outs(TRAP));
                push(TRAP, rbit(), rbit(), rop(), 1'b1, rst_gate(st_outs(TRAP)));
            end
        endcase
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [7];
        logic [5:0] r;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
        if ($urandom_range(0, 19) == 0) begin
            r = rop();
            foreach (ops[k]) if (r == ops[k]) r = 6'b111111;
            return r;
        end
        return ops[$urandom_range(0, 6)];
    endfunction

    function automatic int pick_lat();
        if ($urandom_range(0, 7) == 0) return TO + int'($urandom_range(0, 2));
        return int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        outs_t      o_obs;
        logic [5:0] op;
        int         rst_at;
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

        // Reset held with mem_ready high: FETCH outputs with write enables forced off
        push(FETCH, 1'b1, 1'b0, 6'd0, 1'b1, rst_gate(st_outs(FETCH)));
        gen_instr(OP_LW,   0, 0, 0, -1, 0);        // lw, single-cycle memory
        gen_instr(OP_R,    0, 0, 0, -1, 0);        // R-type then addi
        gen_instr(OP_ADDI, 0, 0, 0, -1, 0);
        gen_instr(OP_BEQ,  0, 0, 1, -1, 0);        // beq taken
        gen_instr(OP_BNE,  0, 0, 1, -1, 0);        // bne not taken
        gen_instr(OP_SW,   0, TO, 0, -1, 0);       // store times out
        gen_instr(OP_LW,   1, TO - 1, 0, -1, 0);   // answer on the last allowed cycle
        gen_instr(OP_LW,   0, TO + 1, 0, 2, 0);    // reset during read wait
        gen_instr(OP_J,    TO, 0, 0, -1, 0);       // fetch timeout
        gen_instr(OP_J,    2, 0, 0, -1, 0);
        gen_instr(6'b111111, 0, 0, 0, -1, 20);     // illegal opcode, trap held
        for (int n = 0; n < 200; n++) begin
            op     = pick_op();
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
            gen_instr(op, pick_lat(), pick_lat(), rbit(), rst_at, int'($urandom_range(1, 5)));
        end

        foreach (q[i]) begin
            @(negedge clk);
            reset     = q[i].rst;
            mem_ready = q[i].rdy;
            zero      = q[i].z;
            opcode    = q[i].op;
            #1;
            o_obs = {pc_en, ir_write, iord, mem_read, mem_write, reg_dst, reg_write,
                     mem_to_reg, alu_src_a, illegal_op, bus_error, alu_src_b, alu_op, pc_source};
            $display("cycle %0d: state=%0d rst=%b rdy=%b op=%b outs=%h", i, state,
                     q[i].rst, q[i].rdy, q[i].op, o_obs);
            check($sformatf("cycle%0d_state", i), 32'(state), 32'(q[i].st));
            check($sformatf("cycle%0d_outs", i), 32'(o_obs), 32'(q[i].o));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
